// File: rtl/foreground_line_scheduler.sv
// Scans the OBM Y table for one scanline and assigns hitting objects to renderer slots in index order.
// Latency: start -> obm_addr 0 next cycle; slot write 2 cycles after an address is issued; done 66 cycles after start for 64 objects.
// Backpressure: none; the OBM read never stalls, and a hit beyond MAX_PER_LINE sets overflow and ends the scan early.
module foreground_line_scheduler #(
  parameter int NUM_OBJECTS  = 64,
  parameter int MAX_PER_LINE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] target_y,
  output logic [5:0] obm_addr,
  input  logic [7:0] obm_y,
  output logic       slot_we,
  output logic [2:0] slot_idx,
  output logic [5:0] slot_obma,
  output logic       busy,
  output logic       done,
  output logic [3:0] count,
  output logic       overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [5:0] LAST_ADDR = 6'(NUM_OBJECTS - 1);
  localparam logic [3:0] MAX_CNT   = 4'(MAX_PER_LINE);

  logic [1:0] state;
  logic [7:0] ty;
  logic       rd_vld;
  logic [5:0] rd_idx;
  logic       eval;
  logic       hit;
  logic       full;

  // Returned Y byte belongs to the address issued one cycle earlier (rd_idx).
  assign eval = rd_vld && ((state == SCAN) || (state == DRAIN));
  assign hit  = eval && (obm_y <= ty) && ({1'b0, ty} < ({1'b0, obm_y} + 9'd8));
  assign full = (count == MAX_CNT);

  assign busy = (state == SCAN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ty        <= 8'd0;
      obm_addr  <= 6'd0;
      rd_vld    <= 1'b0;
      rd_idx    <= 6'd0;
      slot_we   <= 1'b0;
      slot_idx  <= 3'd0;
      slot_obma <= 6'd0;
      count     <= 4'd0;
      overflow  <= 1'b0;
    end else begin
      slot_we <= 1'b0;
      rd_vld  <= (state == SCAN);
      rd_idx  <= obm_addr;

      case (state)
        IDLE: begin
          if (start) begin
            ty       <= target_y;
            count    <= 4'd0;
            overflow <= 1'b0;
            obm_addr <= 6'd0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (obm_addr == LAST_ADDR) begin
            state <= DRAIN;
          end else begin
            obm_addr <= obm_addr + 6'd1;
          end
        end
        DRAIN:   state <= DONE;
        default: state <= IDLE;
      endcase

      if (hit) begin
        if (full) begin
          // One hit too many: stop issuing reads; the read still in flight is dropped.
          overflow <= 1'b1;
          obm_addr <= obm_addr;
          state    <= DONE;
        end else begin
          slot_we   <= 1'b1;
          slot_idx  <= count[2:0];
          slot_obma <= rd_idx;
          count     <= count + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_foreground_line_scheduler.sv
// Directed and randomized scans checked against a list-based model of slot assignment and timing.
`timescale 1ns/1ps
module tb_foreground_line_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] target_y = 8'd0;
  logic [5:0] obm_addr;
  logic [7:0] obm_y = 8'd0;
  logic       slot_we;
  logic [2:0] slot_idx;
  logic [5:0] slot_obma;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic       overflow;

  logic [7:0] ymem [64];

  int total = 0;
  int bad   = 0;

  int e_idx[$];
  int e_cyc[$];
  int e_done;
  int e_cnt;
  int e_ovf;

  foreground_line_scheduler #(.NUM_OBJECTS(64), .MAX_PER_LINE(8)) dut (
    .clk(clk), .rst(rst), .start(start), .target_y(target_y),
    .obm_addr(obm_addr), .obm_y(obm_y),
    .slot_we(slot_we), .slot_idx(slot_idx), .slot_obma(slot_obma),
    .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  always #40 clk = ~clk;

  // OBM Y port: registered read, data one cycle after the address.
  always @(posedge clk) obm_y <= ymem[obm_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic bit covers(input int y, input int t);
    return (t >= y) && (t - y < 8);
  endfunction

  // Expected writes: the first 8 covering objects in index order; a 9th ends the scan.
  task automatic model(input int t);
    int n;
    e_idx.delete();
    e_cyc.delete();
    n = 0;
    e_done = 66;
    e_ovf = 0;
    for (int i = 0; i < 64; i++) begin
      if (covers(int'(ymem[i]), t)) begin
        if (n < 8) begin
          e_idx.push_back(i);
          e_cyc.push_back(i + 3);
          n++;
        end else begin
          e_ovf = 1;
          e_done = i + 3;
          break;
        end
      end
    end
    e_cnt = n;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 64; i++) ymem[i] = v;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, obm_addr, 0);
    chk({tag, "_we"}, slot_we, 0);
    chk({tag, "_idx"}, slot_idx, 0);
    chk({tag, "_obma"}, slot_obma, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  // Caller is positioned at a falling edge; start is sampled on the next rising edge.
  task automatic run_scan(input string tag, input int t, input int alt_at, input int alt_t,
                          input bit start_in_done);
    int wi;
    model(t);
    start = 1'b1;
    target_y = 8'(t);
    @(posedge clk);
    wi = 0;
    for (int c = 1; c <= e_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      target_y = ~8'(t);
      if (c == alt_at) begin
        start = 1'b1;
        target_y = 8'(alt_t);
      end
      if (start_in_done && c == e_done) start = 1'b1;
      chk({tag, "_busy"}, busy, (c < e_done));
      chk({tag, "_done"}, done, (c == e_done));
      if (c <= 64 && c < e_done) chk({tag, "_addr"}, obm_addr, c - 1);
      if (slot_we) begin
        if (wi < e_idx.size()) begin
          chk({tag, "_slot_idx"}, slot_idx, wi);
          chk({tag, "_slot_obma"}, slot_obma, e_idx[wi]);
          chk({tag, "_we_cycle"}, c, e_cyc[wi]);
        end else begin
          chk({tag, "_extra_we"}, slot_we, 0);
        end
        wi++;
      end
    end
    chk({tag, "_count"}, count, e_cnt);
    chk({tag, "_ovf"}, overflow, e_ovf);
    chk({tag, "_nwrites"}, wi, e_idx.size());
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_done"}, done, 0);
      chk({tag, "_idle_we"}, slot_we, 0);
      chk({tag, "_hold_count"}, count, e_cnt);
      chk({tag, "_hold_ovf"}, overflow, e_ovf);
    end
  endtask

  initial begin
    fill(8'hFF);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // Two isolated hits; start lands on the first edge after reset release.
    ymem[3] = 8'd10;
    ymem[40] = 8'd14;
    run_scan("two_hits", 12, 0, 0, 1'b0);

    fill(8'hFF);
    for (int i = 0; i < 10; i++) ymem[i] = 8'd20;
    run_scan("overflow", 27, 0, 0, 1'b0);

    fill(8'h80);
    ymem[5] = 8'hFC;
    run_scan("fc_at_ff", 8'hFF, 0, 0, 1'b0);
    run_scan("fc_at_03", 8'h03, 0, 0, 1'b0);
    ymem[5] = 8'h80;
    ymem[6] = 8'hF8;
    ymem[7] = 8'hF0;
    run_scan("f8_at_ff", 8'hFF, 0, 0, 1'b0);
    run_scan("f8_at_f7", 8'hF7, 0, 0, 1'b0);
    run_scan("f0_at_f8", 8'hF8, 0, 0, 1'b0);

    // Restarts while busy and while done must be ignored.
    fill(8'hFF);
    ymem[3] = 8'd10;
    ymem[40] = 8'd14;
    run_scan("restart", 12, 30, 20, 1'b1);

    fill(8'hFF);
    ymem[2] = 8'd100;
    ymem[5] = 8'd100;
    ymem[30] = 8'd100;
    start = 1'b1;
    target_y = 8'd100;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mid_count", count, 2);
    rst = 1'b0;
    #1;
    check_zero("mid_rst");
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_we", slot_we, 0);
      chk("mid_rst_busy", busy, 0);
    end
    rst = 1'b1;
    run_scan("post_rst", 100, 0, 0, 1'b0);

    fill(8'hFF);
    run_scan("no_hits", 0, 0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int t;
      int d;
      t = $urandom_range(0, 255);
      d = $urandom_range(1, 8);
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 15) < d) ymem[i] = 8'(t - $urandom_range(0, 12));
        else ymem[i] = 8'($urandom);
      end
      run_scan("random", t, 0, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/foreground_line_scheduler.md
FOREGROUND_LINE_SCHEDULER -- requirements
Module: foreground_line_scheduler

Interface
REQ-001 SHALL have parameter NUM_OBJECTS, default 64, meaning OBM entries scanned per line (power of two, 2..64).
REQ-002 SHALL have parameter MAX_PER_LINE, default 8, meaning the number of object slots the line renderer holds.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, 12.5875 MHz.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle pulse that begins evaluation of one scanline.
REQ-006 SHALL have port target_y, input, 8 bits: the scanline to evaluate, sampled only on the start cycle.
REQ-007 SHALL have port obm_addr, output, 6 bits: the object index presented to the OBM Y read port.
REQ-008 SHALL have port obm_y, input, 8 bits: the object Y byte, valid exactly one cycle after obm_addr.
REQ-009 SHALL have port slot_we, output, 1 bit: the slot-table write strobe.
REQ-010 SHALL have port slot_idx, output, 3 bits: the slot written.
REQ-011 SHALL have port slot_obma, output, 6 bits: the object index stored into the slot.
REQ-012 SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-013 SHALL have port done, output, 1 bit: a one-cycle pulse when the scan completes.
REQ-014 SHALL have port count, output, 4 bits: the number of slots filled, 0..MAX_PER_LINE.
REQ-015 SHALL have port overflow, output, 1 bit: high when more than MAX_PER_LINE objects hit the line.

Function
REQ-016 SHALL implement the FSM states IDLE, SCAN, DRAIN and DONE.
- IDLE->SCAN on start.
- SCAN->DRAIN after obm_addr=NUM_OBJECTS-1 is issued.
- DRAIN->DONE after the final data is evaluated.
- DONE->IDLE unconditionally.
REQ-017 SHALL, on the edge sampling start in IDLE: latch target_y; clear count and overflow; drive obm_addr=0 in the next cycle; assert busy from the next cycle.
REQ-018 SHALL increment obm_addr by 1 per cycle in SCAN with no stalls, and hold it at its last value outside SCAN.
REQ-019 SHALL register the issued address alongside the read, so the obm_y returned is evaluated against the object index that produced it.
REQ-020 SHALL declare a hit when obm_y <= target_y and {1'b0,target_y} < {1'b0,obm_y}+9'd8.
- The comparison uses 9-bit arithmetic with no wrap.
- obm_y=8'hFC covers lines FC..FF only.
- obm_y=8'hFF covers line FF only.
REQ-021 SHALL grant slots in ascending object-index order, so the lowest index goes to slot 0 (matching foreground priority).
REQ-022 SHALL, on a hit with count<MAX_PER_LINE, assert slot_we in the following cycle with slot_idx=count and slot_obma=the hit index, and increment count.
REQ-023 SHALL, on a hit with count==MAX_PER_LINE:
- set overflow;
- issue no slot write;
- abort SCAN immediately and enter DONE;
- discard the in-flight read.
REQ-024 SHALL time a full scan with NUM_OBJECTS=64 and no overflow as follows: busy high in cycles 1..65 after the start edge; done high in cycle 66 only; busy low during done.
REQ-025 SHALL allow the final slot_we (object 63 hit) to coincide with done.
REQ-026 SHALL ignore start while busy or done is high; target_y is not re-latched.
REQ-027 SHALL hold count and overflow stable from done until the next accepted start.
REQ-028 SHALL keep slot_we low in IDLE and DONE, except as allowed by REQ-025.

Reset
REQ-029 SHALL, on rst low, asynchronously force:
- state=IDLE;
- obm_addr=0;
- slot_we=0, slot_idx=0, slot_obma=0;
- busy=0, done=0, count=0, overflow=0;
- latched target_y=0.
REQ-030 SHALL, on rst asserted mid-scan, abandon the scan with no further slot writes, and idle after release until a new start.
REQ-031 SHALL accept start in the first cycle after rst deasserts.

Verification
REQ-032 SHALL be verified with: Y[3]=10, Y[40]=14, all others FF; start with target_y=12 -> slot0=3 in cycle 6, slot1=40 in cycle 43, count=2, overflow=0, done in cycle 66.
REQ-033 SHALL be verified with: Y[0..9]=20; start with target_y=27 -> slots 0..7 = objects 0..7, overflow=1 after object 8 is evaluated (edge 10), done in cycle 11, no write for object 9.
REQ-034 SHALL be verified with: Y[5]=FC; target_y=FF -> a hit; Y[5]=FC, target_y=03 -> no hit (no wrap); Y[6]=F8, target_y=FF -> a hit, while target_y=F7 -> no hit.
REQ-035 SHALL be verified with: a second start pulse at cycle 30 of a scan -> ignored, done still in cycle 66, results from the first target_y.
REQ-036 SHALL be verified with: rst low at cycle 20 of a scan holding 2 pending hits -> all outputs zero immediately; after release and a new start -> a correct fresh scan with count starting from 0.
REQ-037 SHALL be verified with: all Y=FF and target_y=00 -> count=0, no slot_we, overflow=0, done in cycle 66.
